// File: rtl/pe_rx_sink_pkg.sv
// Shared mesh definitions: flit field layout, node count and receive FSM encoding.
package pe_rx_sink_pkg;

  localparam int NODE_NUM    = 8;
  localparam int SRC_LSB     = 29;
  localparam int SRC_W       = 3;
  localparam int DST_LSB     = 26;
  localparam int DST_W       = 3;
  localparam int SEQ_LSB     = 16;
  localparam int SEQ_FIELD_W = 10;
  localparam int TS_LSB      = 0;
  localparam int TS_FIELD_W  = 16;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RUN  = 2'd1,
    RX_DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pe_rx_sink_if.sv
// Router LOCAL output port towards the PE: flit plus valid, no backpressure.
interface pe_rx_sink_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_r2p;
  logic                  valid_r2p;

  modport master (output data_r2p, output valid_r2p);
  modport slave  (input  data_r2p, input  valid_r2p);
endinterface

// File: rtl/pe_rx_stats.sv
// Latency accumulator: running min, max and saturating 32-bit sum, with synchronous clear.
module pe_rx_stats #(
  parameter int TS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            upd,
  input  logic [TS_W-1:0] lat,
  output logic [TS_W-1:0] latency_min,
  output logic [TS_W-1:0] latency_max,
  output logic [31:0]     latency_sum
);

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [TS_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latency_min <= '1;
      latency_max <= '0;
      latency_sum <= '0;
    end else if (clr) begin
      latency_min <= '1;
      latency_max <= '0;
      latency_sum <= '0;
    end else if (upd) begin
      if (lat < latency_min) latency_min <= lat;
      if (lat > latency_max) latency_max <= lat;
      latency_sum <= sat_add32(latency_sum, lat);
    end
  end

endmodule

// File: rtl/pe_rx_sink.sv
// Receive half of a mesh PE: counts packets, checks routing and latency, flags task completion.
// Optional per-source sequence checking is built when RX_SEQ_CHECK_EN is defined.
module pe_rx_sink
  import pe_rx_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_ID    = 0,
  parameter int SEQ_W      = 10,
  parameter int TS_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      receive_num,
  input  logic             flush,
  input  logic [TS_W-1:0]  cur_time,
  pe_rx_sink_if.slave      rx,
  output logic             task_receive_finish_flag,
  output logic [15:0]      recv_count,
  output logic             so_retrsreq_receive_flag,
  output logic [SEQ_W+2:0] so_retrsreq_receive_num,
  output logic [TS_W-1:0]  latency_min,
  output logic [TS_W-1:0]  latency_max,
  output logic [31:0]      latency_sum,
  output logic             err_flag
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_WIDTH-1:0] flit;
  rx_state_e             state_q, state_d;
  logic                  capture, count_en, late, misroute;
  logic [15:0]           count_nxt;
  logic                  vld_p1;
  logic [DST_W-1:0]      dst_p1;
  logic [TS_W-1:0]       lat_p1;

  assign flit = rx.data_r2p;
  // Once DONE, flits are still taken in so that late arrivals can be flagged.
  assign capture = rx.valid_r2p & ~flush & (enable | (state_q == RX_DONE));

  // ---- S1: register flit fields and compute wrap-safe latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= capture;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      dst_p1 <= flit[DST_LSB +: DST_W];
      lat_p1 <= cur_time - TS_W'(flit[TS_LSB +: TS_FIELD_W]);
    end
  end

  // ---- S2: statistics, error tracking and completion ----
  assign count_en  = vld_p1 & (state_q != RX_DONE);
  assign late      = vld_p1 & (state_q == RX_DONE);
  assign misroute  = count_en & (dst_p1 != DST_W'(NODE_ID));
  assign count_nxt = sat_inc16(recv_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: if (enable) state_d = (receive_num == 16'd0) ? RX_DONE : RX_RUN;
      RX_RUN:  if (count_en && (count_nxt == receive_num)) state_d = RX_DONE;
      default: state_d = state_q;
    endcase
    if (flush) state_d = RX_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_count <= '0;
      err_flag   <= 1'b0;
    end else if (flush) begin
      recv_count <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (count_en)         recv_count <= count_nxt;
      if (late || misroute) err_flag   <= 1'b1;
    end
  end

  assign task_receive_finish_flag = (state_q == RX_DONE);

  pe_rx_stats #(.TS_W(TS_W)) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (flush),
    .upd         (count_en),
    .lat         (lat_p1),
    .latency_min (latency_min),
    .latency_max (latency_max),
    .latency_sum (latency_sum)
  );

`ifdef RX_SEQ_CHECK_EN
  logic [SRC_W-1:0] src_p1;
  logic [SEQ_W-1:0] seq_p1;
  logic [SEQ_W-1:0] exp_q [NODE_NUM];
  logic             gap;

  always_ff @(posedge clk) begin
    if (capture) begin
      src_p1 <= flit[SRC_LSB +: SRC_W];
      seq_p1 <= flit[SEQ_LSB +: SEQ_W];
    end
  end

  assign gap = count_en & (seq_p1 != exp_q[src_p1]);

  // Expected sequence always resyncs to the received one, so a gap is reported once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODE_NUM; i++) exp_q[i] <= '0;
      so_retrsreq_receive_flag <= 1'b0;
      so_retrsreq_receive_num  <= '0;
    end else if (flush) begin
      for (int i = 0; i < NODE_NUM; i++) exp_q[i] <= '0;
      so_retrsreq_receive_flag <= 1'b0;
      so_retrsreq_receive_num  <= '0;
    end else begin
      so_retrsreq_receive_flag <= gap;
      if (gap)      so_retrsreq_receive_num <= {src_p1, exp_q[src_p1]};
      if (count_en) exp_q[src_p1] <= seq_p1 + SEQ_W'(1);
    end
  end
`else
  logic unused_fields;
  assign unused_fields            = ^{flit[SRC_LSB +: SRC_W], flit[SEQ_LSB +: SEQ_W]};
  assign so_retrsreq_receive_flag = 1'b0;
  assign so_retrsreq_receive_num  = '0;
`endif

endmodule

// File: tb/tb_pe_rx_sink.sv
// Directed bench for pe_rx_sink: statistics, completion, errors, flush, reset, throughput, sequence gaps.
module tb_pe_rx_sink;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] receive_num;
  logic        flush;
  logic [15:0] cur_time;
  logic        finish_flag;
  logic [15:0] recv_count;
  logic        retr_flag;
  logic [12:0] retr_num;
  logic [15:0] lat_min;
  logic [15:0] lat_max;
  logic [31:0] lat_sum;
  logic        err_flag;

  int checks = 0;
  int errors = 0;

  pe_rx_sink_if #(.DATA_WIDTH(32)) bus ();

  pe_rx_sink #(.DATA_WIDTH(32), .NODE_ID(0), .SEQ_W(10), .TS_W(16)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .enable                   (enable),
    .receive_num              (receive_num),
    .flush                    (flush),
    .cur_time                 (cur_time),
    .rx                       (bus),
    .task_receive_finish_flag (finish_flag),
    .recv_count               (recv_count),
    .so_retrsreq_receive_flag (retr_flag),
    .so_retrsreq_receive_num  (retr_num),
    .latency_min              (lat_min),
    .latency_max              (lat_max),
    .latency_sum              (lat_sum),
    .err_flag                 (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [2:0] s, input logic [2:0] d,
                                     input logic [9:0] q, input logic [15:0] t);
    return {s, d, q, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, then wait for the next falling edge (sampling point).
  task automatic drive(input logic v, input logic [31:0] d);
    bus.valid_r2p = v;
    bus.data_r2p  = d;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; receive_num = 16'd0; flush = 1'b0; cur_time = 16'd0;
    bus.valid_r2p = 1'b0; bus.data_r2p = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_finish", finish_flag, 0);
    chk("rst_count",  recv_count,  0);
    chk("rst_min",    lat_min,     16'hFFFF);
    chk("rst_max",    lat_max,     0);
    chk("rst_sum",    lat_sum,     0);
    chk("rst_err",    err_flag,    0);
    chk("rst_retr",   retr_flag,   0);
    rst_n = 1'b1;

    // Three flits with latencies 5, 9, 7 and receive_num 3
    receive_num = 16'd3; enable = 1'b1; cur_time = 16'd100;
    drive(0, 0);
    drive(1, mk(3'd1, 3'd0, 10'd0, 16'd95));
    drive(1, mk(3'd1, 3'd0, 10'd1, 16'd91));
    drive(1, mk(3'd1, 3'd0, 10'd2, 16'd93));
    chk("t1_count_mid",  recv_count,  2);
    chk("t1_finish_mid", finish_flag, 0);
    drive(0, 0);
    chk("t1_count",  recv_count,  3);
    chk("t1_finish", finish_flag, 1);
    chk("t1_min",    lat_min,     5);
    chk("t1_max",    lat_max,     9);
    chk("t1_sum",    lat_sum,     21);
    chk("t1_err",    err_flag,    0);

    // Flit after completion
    drive(1, mk(3'd1, 3'd0, 10'd3, 16'd95));
    drive(0, 0);
    chk("late_err",   err_flag,   1);
    chk("late_count", recv_count, 3);
    chk("late_sum",   lat_sum,    21);

    // Flush out of DONE
    flush = 1'b1; enable = 1'b0;
    drive(0, 0);
    flush = 1'b0;
    chk("fl1_finish", finish_flag, 0);
    chk("fl1_count",  recv_count,  0);
    chk("fl1_err",    err_flag,    0);
    chk("fl1_min",    lat_min,     16'hFFFF);

    // Timestamp wrap: FFFE -> 0003 is latency 5
    receive_num = 16'd10; enable = 1'b1; cur_time = 16'd3;
    drive(0, 0);
    drive(1, mk(3'd1, 3'd0, 10'd0, 16'hFFFE));
    drive(0, 0);
    chk("wrap_count", recv_count, 1);
    chk("wrap_min",   lat_min,    5);
    chk("wrap_max",   lat_max,    5);
    chk("wrap_sum",   lat_sum,    5);
    chk("wrap_err",   err_flag,   0);

    // Misrouted flit: flagged but still counted
    drive(1, mk(3'd1, 3'd3, 10'd1, 16'd1));
    drive(0, 0);
    chk("mis_err",    err_flag,    1);
    chk("mis_count",  recv_count,  2);
    chk("mis_min",    lat_min,     2);
    chk("mis_sum",    lat_sum,     7);
    chk("mis_finish", finish_flag, 0);

    // Flush on the same cycle as a valid flit
    flush = 1'b1;
    drive(1, mk(3'd1, 3'd0, 10'd2, 16'd2));
    flush = 1'b0; enable = 1'b0;
    drive(0, 0);
    chk("fl2_count", recv_count, 0);
    chk("fl2_min",   lat_min,    16'hFFFF);
    chk("fl2_max",   lat_max,    0);
    chk("fl2_sum",   lat_sum,    0);
    chk("fl2_err",   err_flag,   0);
    drive(0, 0);
    chk("fl2_drop_count", recv_count, 0);

    // receive_num 0 completes with no traffic
    receive_num = 16'd0; enable = 1'b1;
    drive(0, 0);
    chk("rn0_finish", finish_flag, 1);
    chk("rn0_count",  recv_count,  0);
    flush = 1'b1; enable = 1'b0;
    drive(0, 0);
    flush = 1'b0;
    chk("rn0_flush_finish", finish_flag, 0);

    // 100 back-to-back flits
    receive_num = 16'd200; enable = 1'b1; cur_time = 16'd50;
    drive(0, 0);
    for (int i = 0; i < 100; i++) drive(1, mk(3'd1, 3'd0, 10'(i), 16'd49));
    drive(0, 0);
    drive(0, 0);
    chk("thr_count", recv_count, 100);
    chk("thr_sum",   lat_sum,    100);
    chk("thr_min",   lat_min,    1);
    chk("thr_err",   err_flag,   0);

    // Same burst with enable low for 10 cycles
    flush = 1'b1;
    drive(0, 0);
    flush = 1'b0;
    drive(0, 0);
    for (int i = 0; i < 100; i++) begin
      enable = !(i >= 40 && i < 50);
      drive(1, mk(3'd1, 3'd0, 10'(i), 16'd49));
    end
    enable = 1'b1;
    drive(0, 0);
    drive(0, 0);
    chk("pause_count",  recv_count,  90);
    chk("pause_sum",    lat_sum,     90);
    chk("pause_finish", finish_flag, 0);

    // Asynchronous reset in the middle of a burst
    flush = 1'b1;
    drive(0, 0);
    flush = 1'b0;
    drive(0, 0);
    for (int i = 0; i < 5; i++) drive(1, mk(3'd1, 3'd0, 10'(i), 16'd40));
    chk("arst_pre_count", recv_count, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", recv_count, 0);
    chk("arst_min",   lat_min,    16'hFFFF);
    chk("arst_max",   lat_max,    0);
    chk("arst_sum",   lat_sum,    0);
    bus.valid_r2p = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Sequence gap: src 2 sends 0, 1, 4, 5
    receive_num = 16'd100; enable = 1'b1; cur_time = 16'd10;
    drive(0, 0);
    drive(1, mk(3'd2, 3'd0, 10'd0, 16'd9));
    drive(1, mk(3'd2, 3'd0, 10'd1, 16'd9));
    chk("seq_ok0", retr_flag, 0);
    drive(1, mk(3'd2, 3'd0, 10'd4, 16'd9));
    chk("seq_ok1", retr_flag, 0);
    drive(1, mk(3'd2, 3'd0, 10'd5, 16'd9));
`ifdef RX_SEQ_CHECK_EN
    chk("seq_gap_flag", retr_flag, 1);
    chk("seq_gap_num",  retr_num,  13'h0802);
`else
    chk("seq_off_flag", retr_flag, 0);
    chk("seq_off_num",  retr_num,  0);
`endif
    drive(0, 0);
    chk("seq_after_gap", retr_flag, 0);
    chk("seq_count",     recv_count, 4);

    // Wrap 1023 -> 0 on src 4 (first flit from a fresh source is itself a gap)
    drive(1, mk(3'd4, 3'd0, 10'd1023, 16'd9));
    drive(1, mk(3'd4, 3'd0, 10'd0, 16'd9));
`ifdef RX_SEQ_CHECK_EN
    chk("seqw_first_flag", retr_flag, 1);
    chk("seqw_first_num",  retr_num,  13'h1000);
`else
    chk("seqw_off_flag", retr_flag, 0);
`endif
    drive(0, 0);
    chk("seqw_wrap_flag", retr_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_rx_sink.md
Name: pe_rx_sink

Overview:
- Receive half of a mesh PE: consumes flits from the router LOCAL output port (data_r2p/valid_r2p).
- Counts packets, checks destination and per-source sequence, and accumulates latency statistics (min/max/sum).
- Raises task_receive_finish_flag once the programmed receive count is reached.
- Counterpart of the PE traffic transmitter that drives data_p2r/valid_p2r.

Parameters:
- DATA_WIDTH, 32, flit width.
- NODE_ID, 0, this node's 3-bit mesh ID (0..7).
- SEQ_W, 10, sequence-number width.
- TS_W, 16, timestamp and latency width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- enable  in  1  receive enable; low pauses the block.
- receive_num  in  16  packets expected for the task.
- flush  in  1  synchronous clear of all state and statistics.
- cur_time  in  TS_W  global timebase shared with the transmitters.
- data_r2p  in  DATA_WIDTH  flit from the router.
- valid_r2p  in  1  flit valid; no backpressure exists, so the sink accepts every cycle.
- task_receive_finish_flag  out  1  task complete, held until flush.
- recv_count  out  16  packets accepted.
- so_retrsreq_receive_flag  out  1  one-cycle sequence-gap pulse.
- so_retrsreq_receive_num  out  SEQ_W+3  {src_id, missing seq}.
- latency_min  out  TS_W  minimum latency.
- latency_max  out  TS_W  maximum latency.
- latency_sum  out  32  summed latency.
- err_flag  out  1  sticky: misrouted flit, or flit arriving after completion.

Behaviour:
- Clock/reset: one clock clk. Reset rst_n is asynchronous, active-low.
- Flit format: [31:29] src_id, [28:26] dst_id, [25:16] seq, [15:0] timestamp.
- Reset values of outputs:
  - latency_min = all ones.
  - Every other output = 0.
- Internal reset values:
  - State = IDLE.
  - Expected-sequence table exp[0..7] = 0.
- Pipeline, two stages:
  - S1 registers the flit and valid, and computes lat = cur_time - timestamp (mod 2^TS_W, wrap-safe).
  - S2 updates the statistics.
  - Outputs reflect a flit 2 cycles after its valid_r2p.
- FSM states:
  - IDLE: go to RUN when enable=1. If receive_num==0, go to DONE instead and assert the finish flag the next cycle.
  - RUN: S1 captures only while enable=1; with enable=0 flits are dropped, state and statistics hold. When an S2 update makes recv_count == receive_num, go to DONE.
  - DONE: task_receive_finish_flag=1. Any valid flit sets err_flag and is not counted.
  - flush from any state: return to IDLE and clear everything to reset values. flush beats a same-cycle valid flit; the flit is dropped and both pipeline stages are cleared.
- S2 update for a valid flit:
  - If dst_id != NODE_ID: set err_flag. The flit is still counted.
  - recv_count increments, saturating at FFFF.
  - latency_min = min(latency_min, lat); latency_max = max(latency_max, lat).
  - latency_sum += lat, saturating at 32'hFFFFFFFF.
- Back-to-back flits every cycle are sustained with no loss.
- Changing receive_num mid-RUN takes effect on the next compare.
- Reset asserted mid-operation clears everything immediately and asynchronously.

Optional Feature:
- Macro: RX_SEQ_CHECK_EN.
- Defined:
  - S2 compares seq with exp[src_id].
  - On mismatch, pulse so_retrsreq_receive_flag for 1 cycle with num = {src_id, exp[src_id]}.
  - exp[src_id] = seq+1 in all cases (mod 2^SEQ_W wrap; 1023 -> 0 is a match, not a gap).
- Undefined: no exp table; so_retrsreq_receive_flag and so_retrsreq_receive_num are tied to 0.

Decomposition:
- Shared package/global include holds:
  - Flit field offsets and widths (SRC, DST, SEQ, TS).
  - FSM state encodings.
  - Node-count constant (8).
  - These are reused by the transmitter and by the mesh top.
- One natural sub-module: pe_rx_stats (the min/max/saturating-sum accumulator with clear), instantiated once.

Test Plan:
- Min/max/sum and finish: receive_num=3; flits from src 1 to NODE_ID with seq 0,1,2 and latencies 5,9,7 (timestamp = cur_time-lat) -> latency_min=5, max=9, sum=21, recv_count=3, finish=1 two cycles after the last valid.
- Timestamp wrap: timestamp=FFFE with cur_time=0003 -> lat=5, no overflow artifacts.
- Sequence gap (RX_SEQ_CHECK_EN): src 2 sends seq 0,1,4 -> one-cycle retrsreq pulse, num={3'd2,10'd2}; next seq 5 -> no pulse. Seq 1023 then 0 -> no pulse.
- Misroute/late/receive_num 0:
  - Flit with dst_id != NODE_ID -> err_flag=1 and counted.
  - Flit arriving in DONE -> err_flag=1, recv_count unchanged.
  - receive_num=0 plus enable -> finish with no traffic.
- Flush and reset:
  - flush on the same cycle as a valid flit mid-RUN -> flit dropped, all stats back to reset values, state IDLE.
  - rst_n pulsed mid-burst -> outputs immediately at reset values.
- Throughput and pause: 100 consecutive valid cycles -> recv_count=100. With enable=0 for 10 of those cycles -> recv_count=90.
